// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel divider, scan counters, registered sync/blank decodes and RGB pin stage.
// Build option VGA_SYNC_ALIGN_EN delays the syncs by one pixel so they line up with vga_r/g/b.
module vga_sync_gen #(
  parameter int CLK_DIV         = 2,
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       R_in,
  input  logic       G_in,
  input  logic       B_in,
  output logic [9:0] CounterX,
  output logic [9:0] CounterY,
  output logic       inDisplayArea,
  output logic       PixelTick,
  output logic       FrameTick,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       cnt_x_q, cnt_x_d;
  logic [9:0]       cnt_y_q, cnt_y_d;
  logic             disp_q, disp_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             frame_q, frame_d;
  logic [2:0]       rgb_q, rgb_d;

  logic       tick;
  logic [9:0] x_nxt, y_nxt;
  logic       hs_act, vs_act;

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST) && !Reset;
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
  end

  // Next scan position; only committed on a pixel tick.
  always_comb begin
    x_nxt = cnt_x_q + 10'd1;
    y_nxt = cnt_y_q;
    if (cnt_x_q == X_LAST) begin
      x_nxt = '0;
      y_nxt = (cnt_y_q == Y_LAST) ? 10'd0 : cnt_y_q + 10'd1;
    end
  end

  // Decodes are taken from the next position so they match the counters they are presented with.
  always_comb begin
    hs_act  = (x_nxt >= HS_START) && (x_nxt < HS_END);
    vs_act  = (y_nxt >= VS_START) && (y_nxt < VS_END);
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    disp_d  = disp_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    rgb_d   = rgb_q;
    frame_d = 1'b0;
    if (tick) begin
      cnt_x_d = x_nxt;
      cnt_y_d = y_nxt;
      disp_d  = (x_nxt < X_VIS) && (y_nxt < Y_VIS);
      hs_d    = hs_act ? ~SYNC_IDLE : SYNC_IDLE;
      vs_d    = vs_act ? ~SYNC_IDLE : SYNC_IDLE;
      frame_d = (x_nxt == 10'd0) && (y_nxt == 10'd0);
      rgb_d   = {R_in, G_in, B_in} & {3{disp_q}};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt_q <= '0;
      cnt_x_q   <= X_LAST;
      cnt_y_q   <= Y_LAST;
      disp_q    <= 1'b0;
      hs_q      <= SYNC_IDLE;
      vs_q      <= SYNC_IDLE;
      frame_q   <= 1'b0;
      rgb_q     <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      cnt_x_q   <= cnt_x_d;
      cnt_y_q   <= cnt_y_d;
      disp_q    <= disp_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      frame_q   <= frame_d;
      rgb_q     <= rgb_d;
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic hs_dly_q, hs_dly_d;
  logic vs_dly_q, vs_dly_d;

  always_comb begin
    hs_dly_d = tick ? hs_q : hs_dly_q;
    vs_dly_d = tick ? vs_q : vs_dly_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_dly_q <= SYNC_IDLE;
      vs_dly_q <= SYNC_IDLE;
    end else begin
      hs_dly_q <= hs_dly_d;
      vs_dly_q <= vs_dly_d;
    end
  end

  assign vga_h_sync = hs_dly_q;
  assign vga_v_sync = vs_dly_q;
`else
  assign vga_h_sync = hs_q;
  assign vga_v_sync = vs_q;
`endif

  assign CounterX      = cnt_x_q;
  assign CounterY      = cnt_y_q;
  assign inDisplayArea = disp_q;
  assign PixelTick     = tick;
  assign FrameTick     = frame_q;
  assign vga_r         = rgb_q[2];
  assign vga_g         = rgb_q[1];
  assign vga_b         = rgb_q[0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized bench for vga_sync_gen on a shrunken raster, checked against an arithmetic scan model.
module tb_vga_sync_gen;

  localparam int CD  = 2;
  localparam int HA  = 8;
  localparam int HF  = 2;
  localparam int HS  = 3;
  localparam int HB  = 2;
  localparam int VA  = 4;
  localparam int VF  = 1;
  localparam int VS  = 2;
  localparam int VB  = 2;
  localparam int SAL = 1;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       Clk = 1'b0;
  logic       Reset, R_in, G_in, B_in;
  logic [9:0] CounterX, CounterY;
  logic       inDisplayArea, PixelTick, FrameTick;
  logic       vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b;

  int n_chk = 0;
  int n_err = 0;

  logic [2:0] rgb_tab [FRAME];

  always #5 Clk = ~Clk;

  vga_sync_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE_LOW(SAL)
  ) dut (
    .Clk(Clk), .Reset(Reset), .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .CounterX(CounterX), .CounterY(CounterY), .inDisplayArea(inDisplayArea),
    .PixelTick(PixelTick), .FrameTick(FrameTick),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Position index after t pixel ticks since reset; t=0 is the reset position (last pixel of frame).
  function automatic int pos_of(input int t);
    return (t == 0) ? FRAME - 1 : (t - 1) % FRAME;
  endfunction

  function automatic bit vis(input int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic bit hact(input int p);
    return ((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HS);
  endfunction

  function automatic bit vact(input int p);
    return ((p / HT) >= VA + VF) && ((p / HT) < VA + VF + VS);
  endfunction

  function automatic logic lvl(input bit act);
    return (SAL != 0) ? !act : act;
  endfunction

  task automatic refill();
    for (int i = 0; i < FRAME; i++) rgb_tab[i] = 3'($urandom);
  endtask

  initial begin
    int  c, t, p, pp, rst_left;
    bit  rst_prev, sched_done, new_rst;
    logic [2:0] rgb_exp;
    logic hs_exp, vs_exp;

    refill();
    Reset = 1'b1; R_in = 1'b0; G_in = 1'b0; B_in = 1'b0;
    rst_left = 3;
    c = 0;
    sched_done = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge Clk); #1;
      rst_prev = Reset;
      c = rst_prev ? 0 : c + 1;
      t = c / CD;
      p = pos_of(t);
      pp = (t >= 1) ? pos_of(t - 1) : FRAME - 1;

      new_rst = 1'b0;
      if (rst_left > 0) begin
        Reset = 1'b1;
        rst_left--;
      end else if (cyc > 700 && !sched_done && t >= 1 && hact(p) && vact(p)) begin
        // reset in the middle of both sync pulses
        Reset = 1'b1; new_rst = 1'b1; sched_done = 1'b1;
      end else if (cyc > 1200 && $urandom_range(0, 149) == 0) begin
        Reset = 1'b1; new_rst = 1'b1;
        rst_left = $urandom_range(0, 2);
      end else begin
        Reset = 1'b0;
      end
      {R_in, G_in, B_in} = rgb_tab[p];
      #1;

      chk("CounterX", CounterX, p % HT);
      chk("CounterY", CounterY, p / HT);
      chk("PixelTick", PixelTick, ((c % CD) == CD - 1) && !Reset);
      chk("FrameTick", FrameTick, (t >= 1) && (p == 0) && ((c % CD) == 0));
      chk("inDisplayArea", inDisplayArea, (t >= 1) && vis(p));
`ifdef VGA_SYNC_ALIGN_EN
      hs_exp = (t >= 2) ? lvl(hact(pp)) : lvl(1'b0);
      vs_exp = (t >= 2) ? lvl(vact(pp)) : lvl(1'b0);
`else
      hs_exp = (t >= 1) ? lvl(hact(p)) : lvl(1'b0);
      vs_exp = (t >= 1) ? lvl(vact(p)) : lvl(1'b0);
`endif
      chk("vga_h_sync", vga_h_sync, hs_exp);
      chk("vga_v_sync", vga_v_sync, vs_exp);
      rgb_exp = (t >= 2 && vis(pp)) ? rgb_tab[pp] : 3'b000;
      chk("vga_r", vga_r, rgb_exp[2]);
      chk("vga_g", vga_g, rgb_exp[1]);
      chk("vga_b", vga_b, rgb_exp[0]);

      if (new_rst) refill();
    end

    chk("mid_sync_reset_seen", sched_done, 1'b1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
